// File: rtl/bbox_pkg.sv
// Shared types and widths for the multi-channel bounding-box extractor.
package bbox_pkg;

  localparam int HCOUNT_W    = 11;
  localparam int VCOUNT_W    = 10;
  localparam int COUNT_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } emit_state_t;

  // Count is carried at full width; the top level narrows it to CNT_W on output.
  typedef struct packed {
    logic                   found;
    logic [HCOUNT_W-1:0]    x;
    logic [VCOUNT_W-1:0]    y;
    logic [HCOUNT_W-1:0]    w;
    logic [VCOUNT_W-1:0]    h;
    logic [COUNT_MAX_W-1:0] count;
  } bbox_result_t;

endpackage

// File: rtl/bbox_extent_acc.sv
// Single-channel min/max extent and saturating pixel-count accumulator.
// Snapshot outputs carry the post-update value so a hit on the clearing cycle is kept.
module bbox_extent_acc
  import bbox_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                clear_in,
  input  logic                hit_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic [HCOUNT_W-1:0] min_x,
  output logic [VCOUNT_W-1:0] min_y,
  output logic [HCOUNT_W-1:0] max_x,
  output logic [VCOUNT_W-1:0] max_y,
  output logic [CNT_W-1:0]    count
);

  logic [HCOUNT_W-1:0] min_x_p0;
  logic [VCOUNT_W-1:0] min_y_p0;
  logic [HCOUNT_W-1:0] max_x_p0;
  logic [VCOUNT_W-1:0] max_y_p0;
  logic [CNT_W-1:0]    count_p0;

  always_comb begin
    min_x = min_x_p0;
    min_y = min_y_p0;
    max_x = max_x_p0;
    max_y = max_y_p0;
    count = count_p0;
    if (hit_in) begin
      if (hcount_in < min_x_p0) min_x = hcount_in;
      if (vcount_in < min_y_p0) min_y = vcount_in;
      if (hcount_in > max_x_p0) max_x = hcount_in;
      if (vcount_in > max_y_p0) max_y = vcount_in;
      if (count_p0 != '1)       count = count_p0 + 1'b1;
    end
  end

  // Stage p0: accumulator state; empty means min at all-ones, max and count at zero.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      min_x_p0 <= '1;
      min_y_p0 <= '1;
      max_x_p0 <= '0;
      max_y_p0 <= '0;
      count_p0 <= '0;
    end else begin
      min_x_p0 <= min_x;
      min_y_p0 <= min_y;
      max_x_p0 <= max_x;
      max_y_p0 <= max_y;
      count_p0 <= count;
    end
  end

endmodule

// File: rtl/multi_bounding_box.sv
// Per-frame multi-channel bounding-box extractor: accumulates extents per mask
// channel, snapshots on frame end and streams one result per channel.
module multi_bounding_box
  import bbox_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int H_PIXELS  = 1280,
  parameter  int V_PIXELS  = 720,
  parameter  int MIN_COUNT = 16,
  parameter  int CNT_W     = 20,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic [NUM_CH-1:0]   mask_in,
  input  logic                tabulate_in,
  input  logic                ready_in,
  output logic                valid_out,
  output logic [CH_W-1:0]     ch_out,
  output logic                found_out,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic [HCOUNT_W-1:0] w_out,
  output logic [VCOUNT_W-1:0] h_out,
  output logic [CNT_W-1:0]    count_out,
  output logic                frame_done_out,
  output logic                overrun_out
);

  function automatic bbox_result_t make_result(
    input logic [HCOUNT_W-1:0] mnx,
    input logic [VCOUNT_W-1:0] mny,
    input logic [HCOUNT_W-1:0] mxx,
    input logic [VCOUNT_W-1:0] mxy,
    input logic [CNT_W-1:0]    cnt
  );
    bbox_result_t r;
    r       = '0;
    r.count = COUNT_MAX_W'(cnt);
    if ((cnt != '0) && (COUNT_MAX_W'(cnt) >= COUNT_MAX_W'(MIN_COUNT))) begin
      r.found = 1'b1;
      r.x     = mnx;
      r.y     = mny;
      r.w     = mxx - mnx + 1'b1;
      r.h     = mxy - mny + 1'b1;
    end
    return r;
  endfunction

  logic         in_frame;
  bbox_result_t snap_res [NUM_CH];

  assign in_frame = (int'(hcount_in) < H_PIXELS) && (int'(vcount_in) < V_PIXELS);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_acc
    logic [HCOUNT_W-1:0] mnx, mxx;
    logic [VCOUNT_W-1:0] mny, mxy;
    logic [CNT_W-1:0]    cnt;

    bbox_extent_acc #(.CNT_W(CNT_W)) u_acc (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear_in  (tabulate_in),
      .hit_in    (mask_in[c] && in_frame),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .min_x     (mnx),
      .min_y     (mny),
      .max_x     (mxx),
      .max_y     (mxy),
      .count     (cnt)
    );

    assign snap_res[c] = make_result(mnx, mny, mxx, mxy, cnt);
  end

  emit_state_t  state_q, state_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic         load_bank;
  logic         overrun_q;
  bbox_result_t bank_p1 [NUM_CH];
  bbox_result_t cur;
  logic         unused_count_hi;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_bank = 1'b0;
    case (state_q)
      IDLE: begin
        if (tabulate_in) begin
          state_d   = EMIT;
          idx_d     = '0;
          load_bank = 1'b1;
        end
      end
      EMIT: begin
        if (ready_in) begin
          if (idx_q == CH_W'(NUM_CH - 1)) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= tabulate_in && (state_q != IDLE);
    end
  end

  // Stage p1: result bank, written only when a tabulate is accepted in IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < NUM_CH; c++) bank_p1[c] <= '0;
    end else if (load_bank) begin
      for (int c = 0; c < NUM_CH; c++) bank_p1[c] <= snap_res[c];
    end
  end

  assign cur             = (state_q == EMIT) ? bank_p1[idx_q] : '0;
  assign unused_count_hi = ^cur.count;

  assign valid_out      = (state_q == EMIT);
  assign frame_done_out = (state_q == DONE);
  assign overrun_out    = overrun_q;
  assign ch_out         = idx_q;
  assign found_out      = cur.found;
  assign x_out          = cur.x;
  assign y_out          = cur.y;
  assign w_out          = cur.w;
  assign h_out          = cur.h;
  assign count_out      = cur.count[CNT_W-1:0];

endmodule

// File: doc/multi_bounding_box.md
Name: multi_bounding_box

Overview:
- Per-frame, multi-channel bounding-box extractor for the thresholded pixel stream.
- Tracks true min/max x/y extents and pixel count for NUM_CH independent mask channels (e.g. one per tracked colour) over a frame.
- On each frame-end pulse, snapshots all channels and emits one result per channel over a valid/ready handshake to the overlay/tracking logic.
- Replaces the single-object, centroid-seeded box search with exact extents, a minimum-size qualifier and overrun reporting.

Parameters:
- NUM_CH, 4: number of independent mask channels (1..16).
- H_PIXELS, 1280: active width; pixels with hcount_in >= H_PIXELS are ignored.
- V_PIXELS, 720: active height; pixels with vcount_in >= V_PIXELS are ignored.
- MIN_COUNT, 16: minimum pixel count for a channel to report found.
- CNT_W, 20: width of the per-channel pixel counter, which saturates.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- mask_in  in  NUM_CH  per-channel threshold hit for the current pixel.
- tabulate_in  in  1  single-cycle frame-end pulse.
- ready_in  in  1  downstream accepts the current result.
- valid_out  out  1  result on outputs is valid.
- ch_out  out  $clog2(NUM_CH) (min 1)  channel index of the current result.
- found_out  out  1  channel count >= MIN_COUNT.
- x_out  out  11  box left edge (min x).
- y_out  out  10  box top edge (min y).
- w_out  out  11  box width, max_x - min_x + 1.
- h_out  out  10  box height, max_y - min_y + 1.
- count_out  out  CNT_W  channel pixel count, saturated.
- frame_done_out  out  1  one-cycle pulse after the last channel is accepted.
- overrun_out  out  1  one-cycle pulse when a tabulate is dropped.

Behaviour:
- Clocking: clk_in only; rst_in is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - Every accumulator is empty: min_x = 2047, min_y = 1023, max_x = 0, max_y = 0, count = 0.
  - Result bank is cleared.
- Accumulate (every cycle, per channel c):
  - Update only if mask_in[c] && hcount_in < H_PIXELS && vcount_in < V_PIXELS.
  - min_x/min_y take the minimum, max_x/max_y take the maximum.
  - count increments and saturates at 2^CNT_W-1.
  - Comparisons are unsigned.
- Tabulate at cycle T:
  - The pixel presented at T is included in the snapshot, i.e. the snapshot captures the post-update value.
  - If the FSM is IDLE: the snapshot loads the result bank and the FSM enters EMIT with ch index 0. valid_out is high from T+1.
  - In all cases the accumulators are cleared at T+1. A mask hit at T+1 starts the new frame.
- FSM states:
  - IDLE -> EMIT on tabulate_in.
  - EMIT: while valid_out && ready_in, the index advances. When the index reaches NUM_CH-1 and is accepted, go to DONE.
  - DONE: frame_done_out = 1 for exactly one cycle, valid_out = 0, then IDLE. A tabulate arriving in DONE is treated as an overrun.
- Output data:
  - Outputs are a pure function of the registered result bank and index, with no combinational path from inputs.
  - Outputs hold stable while valid_out && !ready_in.
  - If count < MIN_COUNT (including 0): found_out = 0 and x/y/w/h = 0, but count_out is still reported.
- Overrun:
  - tabulate_in while in EMIT or DONE means the result bank is untouched and the current emission continues unchanged.
  - The accumulators are still cleared.
  - overrun_out pulses for 1 cycle.
- Single-pixel box: w_out = 1, h_out = 1.
- Full-frame box: x = 0, y = 0, w = H_PIXELS, h = V_PIXELS.
- Reset mid-EMIT: aborts immediately with no frame_done_out, and all state returns to reset values.
- Throughput: with ready_in held high, one result per cycle. The frame completes in NUM_CH+1 cycles after tabulate.

Decomposition:
- Package bbox_pkg holds:
  - typedef bbox_result_t: found, x, y, w, h, count.
  - enum emit_state_t: IDLE, EMIT, DONE.
  - Constants HCOUNT_W = 11, VCOUNT_W = 10.
- Sub-module bbox_extent_acc: a single-channel min/max/count accumulator with mask_in, clear_in and snapshot outputs. It is instantiated NUM_CH times via generate.
- The top level holds the result bank, the FSM and the output mux.

Test Plan:
- Channel 0 mask set on a rectangle x 100..149, y 200..219 (1000 px); other channels are idle; tabulate; ready_in = 1. Required: ch 0 reports found = 1, x = 100, y = 200, w = 50, h = 20, count = 1000. Ch 1-3 report found = 0, all fields 0. frame_done_out pulses at T+5.
- Ch 2 has 15 hits with MIN_COUNT = 16 -> found = 0, count_out = 15, x/y/w/h = 0. Add one more hit the next frame -> found = 1.
- Backpressure: ready_in low for 3 cycles on ch 1 -> valid_out stays high, ch_out = 1 and data is stable. Emission then resumes and frame_done_out comes 3 cycles later than the ready_in = 1 case.
- Second tabulate 2 cycles after the first, with ready_in = 0 -> overrun_out pulses once and the emitted data equals the first snapshot. The next frame's results exclude pixels from before the second tabulate.
- Mask hits at hcount 1300 / vcount 730 and a hit at (0,0) -> box x = 0, y = 0, w = 1, h = 1. A hit coinciding with tabulate is counted in the closing frame.
- Assert rst_in during EMIT at ch 2 -> next cycle valid_out = 0 and no frame_done_out. The following frame reports correctly from empty accumulators.
